gray_counter_bank: RTL and testbench

Bank of `CHANNELS` independent Gray-code counters that share a single `IncGrayC` incrementer. A round-robin scheduler grants at most one increment request per cycle. The granted channel's stored Gray value goes through the shared incrementer and is written back on the next clock edge. The block sits next to Gray-coded pointer and event-count logic, where several requesters need Gray counters but one incrementer per counter is too costly.

---
 rtl/gray_bank_pkg.sv | 42 ++++
 rtl/gray_bank_rr_arb.sv | 44 ++++
 rtl/inc_gray_c.sv | 47 ++++
 rtl/gray_counter_bank.sv | 87 ++++++++
 tb/tb_gray_counter_bank.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_bank_pkg.sv
// Shared helpers for the Gray counter bank.
//   gray_wrap_val(width) : Gray code of binary all-ones for a word of 'width' bits
//   rr_pick(elig, ptr, n): first set bit of elig at or after ptr, wrapping modulo n
package gray_bank_pkg;

  localparam int MAX_W  = 64;
  localparam int MAX_CH = 64;
  localparam int IDX_W  = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Binary all-ones maps to a Gray word with only the MSB set.
  function automatic logic [MAX_W-1:0] gray_wrap_val(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] eligible,
                                       input int unsigned       ptr,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned c;
    res = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i < n) begin
        c = ptr + i;
        if (c >= n) c = c - n;
        if (!res.found && eligible[c]) begin
          res.found = 1'b1;
          res.idx   = IDX_W'(c);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gray_bank_rr_arb.sv
// Round-robin arbiter for the Gray counter bank; owns the rotating pointer.
//   clk, rst   : clock, synchronous active-high reset
//   eligible   : per-channel eligible requests (already masked by enable/clear/reset)
//   grant      : one-hot or zero grant, combinational
//   grant_idx  : index of the granted channel
//   grant_vld  : a grant is issued this cycle
//   rr_q       : current search start
module gray_bank_rr_arb
  import gray_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] eligible,
  output logic [CHANNELS-1:0] grant,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_vld,
  output logic [IW-1:0]       rr_q
);

  logic [MAX_CH-1:0] elig_ext;
  rr_pick_t          pick;

  always_comb begin
    elig_ext                 = '0;
    elig_ext[CHANNELS-1:0]   = eligible;
    pick                     = rr_pick(elig_ext, 32'(rr_q), CHANNELS);
    grant_vld                = pick.found;
    grant_idx                = IW'(pick.idx);
    grant                    = '0;
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (grant_vld) begin
      rr_q <= (grant_idx == IW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/inc_gray_c.sv
// IncGrayC: combinational Gray-code incrementer.
//   a  : Gray input word
//   ci : increment enable (carry in)
//   z  : a + ci in Gray order, modulo 2^WIDTH
// SPEED 0 converts through binary; SPEED 1/2 flip a single bit chosen by parity.
module IncGrayC #(
  parameter int WIDTH = 16,
  parameter int SPEED = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  output logic [WIDTH-1:0] z
);

  if (SPEED == 0) begin : g_slow
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] sum;
    always_comb begin
      bin[WIDTH-1] = a[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) bin[i] = bin[i+1] ^ a[i];
      sum = bin + WIDTH'(ci);
      z   = sum ^ (sum >> 1);
    end
  end else begin : g_fast
    // Even parity: flip bit 0. Odd parity: flip the bit left of the lowest set bit;
    // when that lowest set bit is the MSB, clearing it wraps to zero.
    logic found;
    always_comb begin
      z     = a;
      found = 1'b0;
      if (ci) begin
        if (!(^a)) begin
          z[0] = ~a[0];
        end else begin
          for (int i = 0; i < WIDTH - 1; i++) begin
            if (!found && a[i]) begin
              z[i+1] = ~a[i+1];
              found  = 1'b1;
            end
          end
          if (!found) z[WIDTH-1] = ~a[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: rtl/gray_counter_bank.sv
// Bank of Gray counters sharing one incrementer behind a round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : global enable for grants
//   inc_req_i    : per-channel level increment request
//   clr_i        : per-channel synchronous clear (wins over increment)
//   inc_ack_o    : one-hot/zero grant in the request cycle
//   cnt_o        : registered counters, channel c at [c*WIDTH +: WIDTH]
//   wrap_o       : previous cycle's grant wrapped its counter to zero
//   wrap_id_o    : channel that wrapped
module gray_counter_bank
  import gray_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SPEED    = 2,
  parameter int IW       = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [CHANNELS-1:0]       inc_req_i,
  input  logic [CHANNELS-1:0]       clr_i,
  output logic [CHANNELS-1:0]       inc_ack_o,
  output logic [CHANNELS*WIDTH-1:0] cnt_o,
  output logic                      wrap_o,
  output logic [IW-1:0]             wrap_id_o
);

  localparam logic [WIDTH-1:0] WRAP_VAL = WIDTH'(gray_wrap_val(WIDTH));

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  logic [IW-1:0]       rr_q;
  logic [WIDTH-1:0]    sel_val;
  logic [WIDTH-1:0]    inc_val;

  // Reset masks arbitration so no ack is shown in the reset cycle.
  assign eligible  = (en_i && !rst_i) ? (inc_req_i & ~clr_i) : '0;
  assign inc_ack_o = grant;

  gray_bank_rr_arb #(
    .CHANNELS (CHANNELS),
    .IW       (IW)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .rr_q      (rr_q)
  );

  assign sel_val = cnt_q[grant_idx];

  IncGrayC #(
    .WIDTH (WIDTH),
    .SPEED (SPEED)
  ) u_inc (
    .a  (sel_val),
    .ci (1'b1),
    .z  (inc_val)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      wrap_o    <= 1'b0;
      wrap_id_o <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr_i[c])      cnt_q[c] <= '0;
        else if (grant[c]) cnt_q[c] <= inc_val;
      end
      wrap_o <= grant_vld && (sel_val == WRAP_VAL);
      if (grant_vld && (sel_val == WRAP_VAL)) wrap_id_o <= grant_idx;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign cnt_o[c*WIDTH +: WIDTH] = cnt_q[c];
  end

endmodule

// File: tb/tb_gray_counter_bank.sv
module tb_gray_counter_bank;

  localparam int W  = 4;
  localparam int CH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic [CH-1:0] inc_req_i = '0;
  logic [CH-1:0] clr_i = '0;
  logic [CH-1:0] inc_ack_o;
  logic [CH*W-1:0] cnt_o;
  logic          wrap_o;
  logic [1:0]    wrap_id_o;

  int errors = 0;
  int checks = 0;

  // Reference model: binary counts, arbitration pointer, wrap flags.
  int m_cnt [CH];
  int m_rr = 0;
  int m_wrap = 0;
  int m_wrap_id = 0;
  int exp_k = -1;
  logic [CH-1:0] exp_ack;

  gray_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SPEED(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .inc_req_i (inc_req_i),
    .clr_i     (clr_i),
    .inc_ack_o (inc_ack_o),
    .cnt_o     (cnt_o),
    .wrap_o    (wrap_o),
    .wrap_id_o (wrap_id_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] gray(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  function automatic logic [W-1:0] dut_cnt(input int c);
    return cnt_o[c*W +: W];
  endfunction

  task automatic set_in(input logic r, input logic e, input logic [CH-1:0] req,
                        input logic [CH-1:0] clr);
    rst_i = r; en_i = e; inc_req_i = req; clr_i = clr;
    exp_k = -1;
    if (!r && e) begin
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (m_rr + i) % CH;
        if (exp_k < 0 && req[c] && !clr[c]) exp_k = c;
      end
    end
    exp_ack = (exp_k >= 0) ? CH'(1 << exp_k) : '0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
      m_rr = 0; m_wrap = 0; m_wrap_id = 0;
    end else begin
      for (int c = 0; c < CH; c++) if (clr_i[c]) m_cnt[c] = 0;
      m_wrap = 0;
      if (exp_k >= 0) begin
        if (m_cnt[exp_k] == (1 << W) - 1) begin
          m_wrap = 1;
          m_wrap_id = exp_k;
        end
        m_cnt[exp_k] = (m_cnt[exp_k] + 1) % (1 << W);
        m_rr = (exp_k + 1) % CH;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b1, '1, '0);
    tick();
    set_in(1'b0, 1'b1, '0, '0);
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, '1, '0);
    checks++;
    if (inc_ack_o !== 4'b0000) begin
      errors++; $display("FAIL reset_ack: got %b want 0000", inc_ack_o);
    end
    tick();
    set_in(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (dut_cnt(c) !== 4'b0000) begin
        errors++; $display("FAIL reset_cnt%0d: got %b want 0000", c, dut_cnt(c));
      end
    end
    checks++;
    if (wrap_o !== 1'b0 || wrap_id_o !== 2'd0) begin
      errors++; $display("FAIL reset_wrap: got %b/%0d want 0/0", wrap_o, wrap_id_o);
    end
  endtask

  task automatic test_single_run();
    int seq [5] = '{0, 1, 3, 2, 6};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      set_in(1'b0, 1'b1, 4'b0001, '0);
      checks++;
      if (inc_ack_o !== 4'b0001) begin
        errors++; $display("FAIL single_ack step%0d: got %b want 0001", s, inc_ack_o);
      end
      checks++;
      if (dut_cnt(0) !== W'(seq[s])) begin
        errors++; $display("FAIL single_cnt step%0d: got %b want %b", s, dut_cnt(0), W'(seq[s]));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int s = 0; s < 15; s++) begin
      set_in(1'b0, 1'b1, 4'b0100, '0);
      tick();
    end
    checks++;
    if (dut_cnt(2) !== 4'b1000) begin
      errors++; $display("FAIL wrap_preset: got %b want 1000", dut_cnt(2));
    end
    set_in(1'b0, 1'b1, 4'b0100, '0);
    checks++;
    if (inc_ack_o !== 4'b0100 || wrap_o !== 1'b0) begin
      errors++; $display("FAIL wrap_ack: got %b/%b want 0100/0", inc_ack_o, wrap_o);
    end
    tick();
    set_in(1'b0, 1'b1, '0, '0);
    checks++;
    if (dut_cnt(2) !== 4'b0000 || wrap_o !== 1'b1 || wrap_id_o !== 2'd2) begin
      errors++;
      $display("FAIL wrap_pulse: got cnt=%b wrap=%b id=%0d want 0000/1/2", dut_cnt(2), wrap_o, wrap_id_o);
    end
    tick();
    checks++;
    if (wrap_o !== 1'b0 || wrap_id_o !== 2'd2) begin
      errors++; $display("FAIL wrap_drop: got %b/%0d want 0/2", wrap_o, wrap_id_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 4'b1111, '0);
      checks++;
      if (inc_ack_o !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL rr_ack cycle%0d: got %b want %b", i, inc_ack_o, 4'(1 << (i % 4)));
      end
      tick();
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (dut_cnt(c) !== 4'b0011) begin
        errors++; $display("FAIL rr_cnt%0d: got %b want 0011", c, dut_cnt(c));
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b1, 4'b0010, '0);
      tick();
    end
    set_in(1'b0, 1'b1, 4'b1010, 4'b0010);
    checks++;
    if (inc_ack_o !== 4'b1000) begin
      errors++; $display("FAIL clr_ack: got %b want 1000", inc_ack_o);
    end
    tick();
    set_in(1'b0, 1'b1, 4'b1111, '0);
    checks++;
    if (dut_cnt(1) !== 4'b0000 || dut_cnt(3) !== 4'b0001) begin
      errors++; $display("FAIL clr_cnt: got %b/%b want 0000/0001", dut_cnt(1), dut_cnt(3));
    end
    checks++;
    if (inc_ack_o !== 4'b0001) begin
      errors++; $display("FAIL clr_rr: got %b want 0001", inc_ack_o);
    end
    tick();
  endtask

  task automatic test_enable();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 4'b1111, (i == 2) ? 4'b0001 : 4'b0000);
      checks++;
      if (inc_ack_o !== 4'b0000) begin
        errors++; $display("FAIL en_ack cycle%0d: got %b want 0000", i, inc_ack_o);
      end
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_cnt(c) !== gray(m_cnt[c])) begin
          errors++; $display("FAIL en_cnt%0d: got %b want %b", c, dut_cnt(c), gray(m_cnt[c]));
        end
      end
    end
    set_in(1'b0, 1'b1, 4'b1111, '0);
    checks++;
    if (inc_ack_o !== 4'b0010) begin
      errors++; $display("FAIL en_resume: got %b want 0010", inc_ack_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 4'b0010, '0);
      tick();
    end
    checks++;
    if (dut_cnt(1) !== 4'b0110) begin
      errors++; $display("FAIL rstmid_preset: got %b want 0110", dut_cnt(1));
    end
    set_in(1'b1, 1'b1, 4'b0010, '0);
    checks++;
    if (inc_ack_o !== 4'b0000) begin
      errors++; $display("FAIL rstmid_ack: got %b want 0000", inc_ack_o);
    end
    tick();
    set_in(1'b0, 1'b1, 4'b1111, '0);
    checks++;
    if (cnt_o !== '0 || wrap_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got cnt=%h wrap=%b want 0/0", cnt_o, wrap_o);
    end
    checks++;
    if (inc_ack_o !== 4'b0001) begin
      errors++; $display("FAIL rstmid_rr: got %b want 0001", inc_ack_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic          r, e;
    logic [CH-1:0] req, clr;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      e   = ($urandom_range(0, 7) != 0);
      req = CH'($urandom);
      clr = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
      set_in(r, e, req, clr);
      checks++;
      if (inc_ack_o !== exp_ack) begin
        errors++; $display("FAIL rand_ack cycle%0d: got %b want %b", i, inc_ack_o, exp_ack);
      end
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_cnt(c) !== gray(m_cnt[c])) begin
          errors++; $display("FAIL rand_cnt%0d cycle%0d: got %b want %b", c, i, dut_cnt(c), gray(m_cnt[c]));
        end
      end
      checks++;
      if (wrap_o !== m_wrap[0] || wrap_id_o !== 2'(m_wrap_id)) begin
        errors++;
        $display("FAIL rand_wrap cycle%0d: got %b/%0d want %0d/%0d", i, wrap_o, wrap_id_o, m_wrap, m_wrap_id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_wrap();
    test_round_robin();
    test_clear();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
